// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: default widths,
// the hardwired-zero register index and the writeback requester IDs.
package rf_write_arbiter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  localparam int REG_ZERO = 0;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  // Index of the k-th candidate when searching upward from base with wrap.
  function automatic int rr_wrap(input int base, input int k, input int n);
    int s;
    s = base + k;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Round-robin picker: searches the valid vector from ptr_i upward with wrap
// and returns a one-hot grant plus its index. Purely combinational.
module rr_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_o && valid_i[rr_wrap(int'(ptr_i), k, NUM_REQ)]) begin
        grant_o[rr_wrap(int'(ptr_i), k, NUM_REQ)] = 1'b1;
        idx_o = IDX_W'(rr_wrap(int'(ptr_i), k, NUM_REQ));
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port among writeback requesters and keeps a
// pending-write scoreboard so decode can stall on read-after-write hazards.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  input  logic [ADDR_W-1:0]         rd1_addr,
  input  logic [ADDR_W-1:0]         rd2_addr,
  output logic                      hazard,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_w,
  output logic [DATA_W-1:0]         rf_data,
  output logic [ID_W-1:0]           grant_id,
  output logic                      err_unres
);

  localparam int NREG = 1 << ADDR_W;

  logic [NUM_REQ-1:0] vld_gated;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [DATA_W-1:0]  gnt_data;
  logic               wr_fire;
  logic               gnt_unres;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_w_q, rf_w_d;
  logic [DATA_W-1:0]  rf_data_q, rf_data_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               err_q, err_d;
  logic [NREG-1:1]    pending_q, pending_d;
  logic [NREG-1:0]    pend_vec;

  // Requests seen while in reset are neither granted nor remembered.
  assign vld_gated = req_valid & {NUM_REQ{rst_n}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .valid_i (vld_gated),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt_onehot),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  assign req_ready = gnt_onehot;

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_onehot[i]) begin
        gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        gnt_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign pend_vec  = {pending_q, 1'b0};
  assign wr_fire   = gnt_any && (gnt_addr != ADDR_W'(REG_ZERO));
  assign gnt_unres = !pend_vec[gnt_addr];
  assign hazard    = pend_vec[rd1_addr] | pend_vec[rd2_addr];

  // grant cycle -> write cycle
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end

    rf_we_d    = wr_fire;
    rf_w_d     = rf_w_q;
    rf_data_d  = rf_data_q;
    grant_id_d = grant_id_q;
    if (wr_fire) begin
      rf_w_d     = gnt_addr;
      rf_data_d  = gnt_data;
      grant_id_d = gnt_idx;
    end
    err_d = wr_fire && gnt_unres;
  end

  // Clear on the register-file write edge; a reservation at the same edge wins.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NREG; i++) begin
      if (rf_we_q && (rf_w_q == ADDR_W'(i))) pending_d[i] = 1'b0;
      if (rsv_valid && (rsv_addr == ADDR_W'(i))) pending_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_w_q     <= '0;
      rf_data_q  <= '0;
      grant_id_q <= '0;
      err_q      <= 1'b0;
      pending_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_w_q     <= rf_w_d;
      rf_data_q  <= rf_data_d;
      grant_id_q <= grant_id_d;
      err_q      <= err_d;
      pending_q  <= pending_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_w      = rf_w_q;
  assign rf_data   = rf_data_q;
  assign grant_id  = grant_id_q;
  assign err_unres = err_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int AW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic [AW-1:0]     rd1_addr;
  logic [AW-1:0]     rd2_addr;
  logic              hazard;
  logic              rf_we;
  logic [AW-1:0]     rf_w;
  logic [DW-1:0]     rf_data;
  logic [0:0]        grant_id;
  logic              err_unres;

  int n_chk = 0;
  int n_err = 0;

  rf_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rd1_addr  (rd1_addr),
    .rd2_addr  (rd2_addr),
    .hazard    (hazard),
    .rf_we     (rf_we),
    .rf_w      (rf_w),
    .rf_data   (rf_data),
    .grant_id  (grant_id),
    .err_unres (err_unres)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    rsv_valid = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic reserve(input logic [AW-1:0] a);
    rsv_valid = 1'b1;
    rsv_addr  = a;
    step();
    rsv_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    req_addr = '0;
    req_data = '0;
    rsv_addr = '0;
    rd1_addr = 2'd1;
    rd2_addr = 2'd2;
    idle();
    step();

    // Reset state, with requests presented during reset
    set_req(REQ_ALU, 2'd1, 8'h11);
    set_req(REQ_LOAD, 2'd3, 8'h33);
    #1 chk("rst_ready", 32'(req_ready), 32'h0);
    step();
    chk("rst_we", 32'(rf_we), 32'h0);
    chk("rst_w", 32'(rf_w), 32'h0);
    chk("rst_data", 32'(rf_data), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_err", 32'(err_unres), 32'h0);
    chk("rst_haz", 32'(hazard), 32'h0);
    rst_n = 1'b1;
    idle();
    rd1_addr = 2'd0;
    rd2_addr = 2'd0;
    step();
    chk("rst_not_kept", 32'(rf_we), 32'h0);

    // Single write to reserved r2
    reserve(2'd2);
    rd1_addr = 2'd2;
    #1 chk("t1_haz_pre", 32'(hazard), 32'h1);
    set_req(REQ_ALU, 2'd2, 8'h5A);
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    step();
    idle();
    chk("t1_we", 32'(rf_we), 32'h1);
    chk("t1_w", 32'(rf_w), 32'h2);
    chk("t1_data", 32'(rf_data), 32'h5A);
    chk("t1_gid", 32'(grant_id), 32'h0);
    chk("t1_err", 32'(err_unres), 32'h0);
    chk("t1_haz_wr", 32'(hazard), 32'h1);
    step();
    chk("t1_we_off", 32'(rf_we), 32'h0);
    chk("t1_haz_post", 32'(hazard), 32'h0);
    chk("t1_data_hold", 32'(rf_data), 32'h5A);

    // Unreserved write from load unit (rr_ptr now 1)
    set_req(REQ_LOAD, 2'd1, 8'hC3);
    #1 chk("unres_ready", 32'(req_ready), 32'h2);
    step();
    idle();
    chk("unres_we", 32'(rf_we), 32'h1);
    chk("unres_w", 32'(rf_w), 32'h1);
    chk("unres_data", 32'(rf_data), 32'hC3);
    chk("unres_gid", 32'(grant_id), 32'h1);
    chk("unres_err", 32'(err_unres), 32'h1);
    step();
    chk("unres_err_pulse", 32'(err_unres), 32'h0);
    chk("unres_we_off", 32'(rf_we), 32'h0);

    // Contention from rr_ptr=0: grants alternate 0,1,0,1
    set_req(REQ_ALU, 2'd1, 8'h11);
    set_req(REQ_LOAD, 2'd3, 8'h33);
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("cont%0d_ready", i), 32'(req_ready), (i % 2) ? 32'h2 : 32'h1);
      step();
      chk($sformatf("cont%0d_we", i), 32'(rf_we), 32'h1);
      chk($sformatf("cont%0d_gid", i), 32'(grant_id), 32'(i % 2));
      chk($sformatf("cont%0d_w", i), 32'(rf_w), (i % 2) ? 32'h3 : 32'h1);
      chk($sformatf("cont%0d_data", i), 32'(rf_data), (i % 2) ? 32'h33 : 32'h11);
    end
    idle();
    step();
    chk("cont_idle_we", 32'(rf_we), 32'h0);

    // Zero register write with r2 pending
    reserve(2'd2);
    rd1_addr = 2'd2;
    set_req(REQ_ALU, 2'd0, 8'hFF);
    #1 chk("zero_ready", 32'(req_ready), 32'h1);
    step();
    idle();
    chk("zero_we", 32'(rf_we), 32'h0);
    chk("zero_err", 32'(err_unres), 32'h0);
    chk("zero_data_hold", 32'(rf_data), 32'h33);
    chk("zero_w_hold", 32'(rf_w), 32'h3);
    chk("zero_haz", 32'(hazard), 32'h1);
    step();
    chk("zero_haz_kept", 32'(hazard), 32'h1);

    // Set/clear collision on r3
    reserve(2'd3);
    rd1_addr = 2'd3;
    set_req(REQ_LOAD, 2'd3, 8'h77);
    step();
    idle();
    rsv_valid = 1'b1;
    rsv_addr  = 2'd3;
    #1;
    chk("coll_we", 32'(rf_we), 32'h1);
    chk("coll_w", 32'(rf_w), 32'h3);
    chk("coll_err", 32'(err_unres), 32'h0);
    chk("coll_haz", 32'(hazard), 32'h1);
    step();
    rsv_valid = 1'b0;
    chk("coll_haz_hold", 32'(hazard), 32'h1);
    set_req(REQ_ALU, 2'd3, 8'h78);
    step();
    idle();
    chk("coll_rewr_we", 32'(rf_we), 32'h1);
    chk("coll_rewr_err", 32'(err_unres), 32'h0);
    step();
    chk("coll_haz_clr", 32'(hazard), 32'h0);

    // Reset mid-stream with r1, r2 pending and a write in flight
    reserve(2'd1);
    rd1_addr = 2'd1;
    rd2_addr = 2'd2;
    #1 chk("mid_haz_pre", 32'(hazard), 32'h1);
    set_req(REQ_ALU, 2'd1, 8'hA1);
    set_req(REQ_LOAD, 2'd3, 8'hB3);
    #1 chk("mid_ready_pre", 32'(req_ready), 32'h2);
    step();
    chk("mid_we_inflight", 32'(rf_we), 32'h1);
    rst_n = 1'b0;
    #1 chk("mid_ready_rst0", 32'(req_ready), 32'h0);
    step();
    chk("mid_we", 32'(rf_we), 32'h0);
    chk("mid_haz", 32'(hazard), 32'h0);
    chk("mid_w", 32'(rf_w), 32'h0);
    chk("mid_data", 32'(rf_data), 32'h0);
    chk("mid_gid", 32'(grant_id), 32'h0);
    #1 chk("mid_ready_rst1", 32'(req_ready), 32'h0);
    step();
    chk("mid_ready_rst2", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    #1 chk("mid_ready_ptr0", 32'(req_ready), 32'h1);
    step();
    idle();
    chk("mid_post_gid", 32'(grant_id), 32'h0);
    chk("mid_post_w", 32'(rf_w), 32'h1);
    chk("mid_post_data", 32'(rf_data), 32'hA1);
    chk("mid_post_err", 32'(err_unres), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
